bin_load_ctrl: RTL
==================

BIN_LOAD_CTRL -- requirements
Module: bin_load_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_CLAUSES 8, clause rows per bin; NUM_VARS 8, local vars; NUM_LVLS 8, local levels; WIDTH_LVL 16, level/bin-number width; WIDTH_VAR_STATES 19, per-var state width; WIDTH_LVL_STATES 11, per-level state width.
REQ-002 One clock; reset is asynchronous and active-low. Ports: clk in 1, clock; rst in 1, async active-low reset.
REQ-003 Host control ports SHALL be: start_load_i in 1, load request pulse; cur_bin_num_i, load_lvl_i, base_lvl_i in WIDTH_LVL each, job parameters; abort_i in 1, cancel job; busy_o out 1, job in progress; done_o out 1, one-cycle job-complete pulse.
REQ-004 Bin memory ports SHALL be: cm_rd_en_o out 1; cm_rd_idx_o out 3; cm_rd_data_i in NUM_VARS*2, valid 1 cycle after cm_rd_en_o; cm_wr_en_o out 1; cm_wr_idx_o out 3; cm_wr_data_o out NUM_VARS*2.
REQ-005 State source ports SHALL be: vs_data_i in WIDTH_VAR_STATES*NUM_VARS; ls_data_i in WIDTH_LVL_STATES*NUM_LVLS. Both are held stable by the host while busy_o=1.
REQ-006 Core-side ports (to sat_engine) SHALL be: wr_carray_o out NUM_CLAUSES; clause_o out NUM_VARS*2; wr_var_states_o out NUM_VARS; vars_states_o out WIDTH_VAR_STATES*NUM_VARS; wr_lvl_states_o out NUM_LVLS; lvl_states_o out WIDTH_LVL_STATES*NUM_LVLS; start_core_o out 1; cur_bin_num_o, load_lvl_o, base_lvl_o out WIDTH_LVL; base_lvl_en_o out 1; done_core_i in 1; sat_i, unsat_i in 1; bkt_lvl_i in WIDTH_LVL; rd_carray_o out NUM_CLAUSES; clause_i in NUM_VARS*2, valid 1 cycle after rd_carray_o bit.
REQ-007 Result ports SHALL be: sat_o, unsat_o out 1; bkt_lvl_o out WIDTH_LVL. All three are registered and valid while done_o=1, then held until the next start.

Function
REQ-008 FSM states SHALL be IDLE, FETCH, WR_VS, WR_LS, START, RUN, READ, FIN.
REQ-009 IDLE: on start_load_i=1, latch cur_bin_num_i, load_lvl_i and base_lvl_i, then go to FETCH. busy_o=1 from the next cycle until FIN exits.
REQ-010 FETCH: counter k runs 0..NUM_CLAUSES. For k<NUM_CLAUSES, drive cm_rd_en_o=1 and cm_rd_idx_o=k. For k>=1, drive wr_carray_o = one-hot(k-1) and clause_o=cm_rd_data_i. Duration is NUM_CLAUSES+1 cycles, then go to WR_VS.
REQ-011 WR_VS: 1 cycle, wr_var_states_o all-ones, vars_states_o=vs_data_i. Then WR_LS: 1 cycle, wr_lvl_states_o all-ones, lvl_states_o=ls_data_i.
REQ-012 START: 1 cycle, start_core_o=1 and base_lvl_en_o=1, with cur_bin_num_o, load_lvl_o and base_lvl_o driven from the latched values; then go to RUN.
REQ-013 RUN: wait for done_core_i=1. In that cycle, capture sat_i, unsat_i and bkt_lvl_i, then go to READ. RUN has no timeout.
REQ-014 READ: counter k runs 0..NUM_CLAUSES. For k<NUM_CLAUSES, rd_carray_o = one-hot(k). For k>=1, cm_wr_en_o=1, cm_wr_idx_o=k-1, cm_wr_data_o=clause_i. Duration is NUM_CLAUSES+1 cycles, then go to FIN.
REQ-015 FIN: 1 cycle, done_o=1, busy_o=0 next cycle, return to IDLE.
REQ-016 All write, read and start strobes SHALL be 0 outside their own state, so no two strobe groups are ever active in the same cycle.
REQ-017 start_load_i SHALL be ignored when not in IDLE, including in the FIN cycle.
REQ-018 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge: all strobes 0 that cycle, no done_o, result registers unchanged. abort_i has priority over done_core_i in the same cycle.
REQ-019 A done_core_i pulse in any state other than RUN SHALL be ignored.
REQ-020 Counter width SHALL be $clog2(NUM_CLAUSES+1). The counter clears on every state entry and never wraps within a state.

Reset
REQ-021 With rst=0 (async), the FSM SHALL be in IDLE. Every output SHALL be 0: strobes, busy_o, done_o, data buses, latched parameters and result registers.
REQ-022 On deassertion, the block SHALL accept start_load_i on the first rising edge.
REQ-023 Reset mid-job SHALL abandon the job with no done_o and no further memory writes.

Verification
REQ-024 Single job: start with bin 1, load_lvl 1, base_lvl 1; core done after 20 cycles with sat_i=1. Required: wr_carray_o 01,02..80 on 8 consecutive cycles; then one cycle of wr_var_states_o=FF; then one cycle of wr_lvl_states_o=FF; then start_core_o pulse with base_lvl_o=1; then 8 write-backs idx 0..7; done_o with sat_o=1.
REQ-025 Data integrity: memory row i = 16'h0101<<i, core echoes rows modified by XOR 16'hFFFF. Required: cm_wr_data_o[i] = ~(16'h0101<<i) for i=0..7.
REQ-026 Unsat result: bin 2, load_lvl 3, base_lvl 2, core returns unsat_i=1 and bkt_lvl_i=1. Required: unsat_o=1, bkt_lvl_o=1, sat_o=0 during done_o.
REQ-027 Abort during RUN, with done_core_i=1 in the same cycle. Required: IDLE next cycle, no rd_carray_o, no done_o; a following job completes normally.
REQ-028 Async reset asserted at FETCH k=4. Required: all outputs 0 immediately; no strobes after release until a new start_load_i.
REQ-029 start_load_i pulsed during READ and during FIN. Required: both ignored; exactly one done_o.

Source files
------------

// File: rtl/bin_load_ctrl.sv
// rtl/bin_load_ctrl.sv - moves one bin of clauses and state into the SAT core, runs it, writes the clauses back
`timescale 1ns/1ps
module bin_load_ctrl #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_load_i,
    input  logic [WIDTH_LVL-1:0]                  cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]                  load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                  base_lvl_i,
    input  logic                                  abort_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  cm_rd_en_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]        cm_rd_idx_o,
    input  logic [NUM_VARS*2-1:0]                 cm_rd_data_i,
    output logic                                  cm_wr_en_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]        cm_wr_idx_o,
    output logic [NUM_VARS*2-1:0]                 cm_wr_data_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]  vs_data_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]  ls_data_i,
    output logic [NUM_CLAUSES-1:0]                wr_carray_o,
    output logic [NUM_VARS*2-1:0]                 clause_o,
    output logic [NUM_VARS-1:0]                   wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]  vars_states_o,
    output logic [NUM_LVLS-1:0]                   wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]  lvl_states_o,
    output logic                                  start_core_o,
    output logic [WIDTH_LVL-1:0]                  cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                  load_lvl_o,
    output logic [WIDTH_LVL-1:0]                  base_lvl_o,
    output logic                                  base_lvl_en_o,
    input  logic                                  done_core_i,
    input  logic                                  sat_i,
    input  logic                                  unsat_i,
    input  logic [WIDTH_LVL-1:0]                  bkt_lvl_i,
    output logic [NUM_CLAUSES-1:0]                rd_carray_o,
    input  logic [NUM_VARS*2-1:0]                 clause_i,
    output logic                                  sat_o,
    output logic                                  unsat_o,
    output logic [WIDTH_LVL-1:0]                  bkt_lvl_o
);
    localparam int CW = $clog2(NUM_CLAUSES + 1);
    localparam int IW = $clog2(NUM_CLAUSES);
    localparam logic [CW-1:0] K_LAST = CW'(NUM_CLAUSES);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR_VS, S_WR_LS, S_START, S_RUN, S_READ, S_FIN
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] k;
    logic [CW-1:0] k_m1;
    logic [IW-1:0] k_idx, km1_idx;
    logic k_first, k_end;
    logic [WIDTH_LVL-1:0] bin_q, load_q, base_q;

    assign k_m1    = k - CW'(1);
    assign k_idx   = k[IW-1:0];
    assign km1_idx = k_m1[IW-1:0];
    assign k_first = (k == '0);
    assign k_end   = (k == K_LAST);

    assign busy_o        = (state != S_IDLE);
    assign cur_bin_num_o = bin_q;
    assign load_lvl_o    = load_q;
    assign base_lvl_o    = base_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            bin_q     <= '0;
            load_q    <= '0;
            base_q    <= '0;
            sat_o     <= 1'b0;
            unsat_o   <= 1'b0;
            bkt_lvl_o <= '0;
        end else begin
            state <= state_nx;
            // k restarts on every state change and parks at K_LAST otherwise
            if (state_nx != state) begin
                k <= '0;
            end else if (!k_end) begin
                k <= k + CW'(1);
            end
            if (state == S_IDLE && start_load_i) begin
                bin_q  <= cur_bin_num_i;
                load_q <= load_lvl_i;
                base_q <= base_lvl_i;
            end
            if (state == S_RUN && done_core_i && !abort_i) begin
                sat_o     <= sat_i;
                unsat_o   <= unsat_i;
                bkt_lvl_o <= bkt_lvl_i;
            end
        end
    end

    always_comb begin
        state_nx        = state;
        done_o          = 1'b0;
        cm_rd_en_o      = 1'b0;
        cm_rd_idx_o     = '0;
        cm_wr_en_o      = 1'b0;
        cm_wr_idx_o     = '0;
        cm_wr_data_o    = '0;
        wr_carray_o     = '0;
        clause_o        = '0;
        wr_var_states_o = '0;
        vars_states_o   = '0;
        wr_lvl_states_o = '0;
        lvl_states_o    = '0;
        start_core_o    = 1'b0;
        base_lvl_en_o   = 1'b0;
        rd_carray_o     = '0;
        // abort silences every strobe in the cycle it is seen, even over done_core_i
        if (abort_i && state != S_IDLE) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_load_i) state_nx = S_FETCH;
                S_FETCH: begin
                    if (!k_end) begin
                        cm_rd_en_o  = 1'b1;
                        cm_rd_idx_o = k_idx;
                    end
                    if (!k_first) begin
                        wr_carray_o = NUM_CLAUSES'(1) << km1_idx;
                        clause_o    = cm_rd_data_i;
                    end
                    if (k_end) state_nx = S_WR_VS;
                end
                S_WR_VS: begin
                    wr_var_states_o = '1;
                    vars_states_o   = vs_data_i;
                    state_nx        = S_WR_LS;
                end
                S_WR_LS: begin
                    wr_lvl_states_o = '1;
                    lvl_states_o    = ls_data_i;
                    state_nx        = S_START;
                end
                S_START: begin
                    start_core_o  = 1'b1;
                    base_lvl_en_o = 1'b1;
                    state_nx      = S_RUN;
                end
                S_RUN: if (done_core_i) state_nx = S_READ;
                S_READ: begin
                    if (!k_end) rd_carray_o = NUM_CLAUSES'(1) << k_idx;
                    if (!k_first) begin
                        cm_wr_en_o   = 1'b1;
                        cm_wr_idx_o  = km1_idx;
                        cm_wr_data_o = clause_i;
                    end
                    if (k_end) state_nx = S_FIN;
                end
                S_FIN: begin
                    done_o   = 1'b1;
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end
endmodule
